// File: rtl/complex_nr_mult_pkg.sv
// Definitions shared by the complex multiplier, its operand feeder and their benches:
// feeder FSM encoding and the field layout of a packed operand word.
package complex_nr_mult_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESENT  = 2'd1,
        WAIT_RDY = 2'd2
    } feeder_state_e;

    // Field index within a packed word; index 3 occupies the most significant slice.
    localparam int NUM_FIELDS   = 4;
    localparam int FIELD_OP1_RE = 3;
    localparam int FIELD_OP1_IM = 2;
    localparam int FIELD_OP2_RE = 1;
    localparam int FIELD_OP2_IM = 0;

    function automatic int field_lsb(input int field, input int dw);
        return field * dw;
    endfunction

endpackage

// File: rtl/complex_nr_op_fifo.sv
// Operand word FIFO with wrap-bit pointers, registered full/empty flags and a
// sticky overflow flag; a write while full is dropped even if a pop happens that cycle.
module complex_nr_op_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sw_rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic             do_wr_s;
    logic             do_rd_s;

    assign do_wr_s = wr_en & ~full_q;
    assign do_rd_s = rd_en & ~empty_q;

    // Next pointers and flags, derived from the post-edge pointers so the flags are registered.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_rd_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        empty_d = (wr_ptr_d == rd_ptr_d);
        ovf_d   = ovf_q | (wr_en & full_q);
    end

    // Pointer, flag and storage registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (sw_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            if (do_wr_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
            end
        end
    end

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign full    = full_q;
    assign empty   = empty_q;
    assign ovf     = ovf_q;

endmodule

// File: rtl/complex_nr_op_feeder.sv
// Operand feeder for the complex multiplier: queues host words and hands them over one
// at a time; a handoff completes when op_ready falls while op_val is high.
module complex_nr_op_feeder
    import complex_nr_mult_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             sw_rst,
    input  logic                             wr_en,
    input  logic [NUM_FIELDS*DATA_WIDTH-1:0] wr_data,
    output logic                             full,
    output logic                             empty,
    output logic                             ovf,
    input  logic                             op_ready,
    output logic                             op_val,
    output logic [NUM_FIELDS*DATA_WIDTH-1:0] op_data,
    output logic [CNT_WIDTH-1:0]             tx_count
);

    localparam int WORD_W = NUM_FIELDS * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    feeder_state_e       state_q;
    logic                op_val_q;
    logic [WORD_W-1:0]   op_data_q;
    logic [CNT_WIDTH-1:0] tx_count_q;
    logic [WORD_W-1:0]   head_s;
    logic                fifo_empty_s;
    logic                pop_s;

    // The head word stays in the FIFO while presented; it is popped only on acceptance.
    assign pop_s = (state_q == PRESENT) & ~op_ready;

    complex_nr_op_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .sw_rst  (sw_rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop_s),
        .rd_data (head_s),
        .full    (full),
        .empty   (fifo_empty_s),
        .ovf     (ovf)
    );

    // Handoff FSM with registered op_val, op_data and handoff counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            op_val_q   <= 1'b0;
            op_data_q  <= '0;
            tx_count_q <= '0;
        end else if (sw_rst) begin
            state_q    <= IDLE;
            op_val_q   <= 1'b0;
            op_data_q  <= '0;
            tx_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty_s) begin
                        op_data_q <= head_s;
                        op_val_q  <= 1'b1;
                        state_q   <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (!op_ready) begin
                        op_val_q   <= 1'b0;
                        tx_count_q <= tx_count_q + CNT_ONE;
                        state_q    <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (op_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    op_val_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign empty    = fifo_empty_s;
    assign op_val   = op_val_q;
    assign op_data  = op_data_q;
    assign tx_count = tx_count_q;

endmodule

// File: tb/tb_complex_nr_op_feeder.sv
// Self-checking bench for complex_nr_op_feeder: directed sequences, a vector table and a
// scoreboard queue that tracks FIFO contents, overflow and handoff count.
module tb_complex_nr_op_feeder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sw_rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        op_ready;
    logic        op_val;
    logic [31:0] op_data;
    logic [15:0] tx_count;

    int checks = 0;
    int fails  = 0;

    logic [31:0] sb[$];
    logic        exp_ovf = 1'b0;
    logic [15:0] exp_tx  = 16'd0;
    logic        prev_val = 1'b0;
    logic [31:0] prev_data = 32'd0;

    typedef struct {
        logic [31:0] word;
        int          delay;
        int          busy;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    complex_nr_op_feeder #(
        .DATA_WIDTH (8),
        .DEPTH      (4),
        .CNT_WIDTH  (16)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .sw_rst   (sw_rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .ovf      (ovf),
        .op_ready (op_ready),
        .op_val   (op_val),
        .op_data  (op_data),
        .tx_count (tx_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard update on each edge using pre-edge values.
    always @(posedge clk) begin
        if (!rstn || sw_rst) begin
            sb.delete();
            exp_ovf = 1'b0;
            exp_tx  = 16'd0;
        end else begin
            logic was_full;
            was_full = (sb.size() == 4);
            if (op_val && !op_ready) begin
                if (sb.size() == 0) begin
                    check("accept_with_empty_model", 64'd1, 64'd0);
                end else begin
                    check("accept_data", op_data, sb[0]);
                    void'(sb.pop_front());
                end
                exp_tx = exp_tx + 16'd1;
            end
            if (wr_en) begin
                if (was_full) exp_ovf = 1'b1;
                else sb.push_back(wr_data);
            end
        end
    end

    // Flag, counter and op_data-stability checks mid-cycle.
    always @(negedge clk) begin
        if (rstn) begin
            check("sb_full", full, sb.size() == 4);
            check("sb_empty", empty, sb.size() == 0);
            check("sb_ovf", ovf, exp_ovf);
            check("sb_tx_count", tx_count, exp_tx);
            if (prev_val && op_val) check("op_data_stable", op_data, prev_data);
        end
        prev_val  = op_val;
        prev_data = op_data;
    end

    task automatic write_word(input logic [31:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_sw_rst();
        sw_rst = 1'b1;
        @(negedge clk);
        sw_rst = 1'b0;
    endtask

    task automatic wait_val();
        int n = 0;
        while (op_val !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_op_val", op_val, 1'b1);
    endtask

    // Multiplier model: accept after `delay` cycles of op_val (0 = already busy), stay busy `busy` cycles.
    task automatic serve(input logic [31:0] w, input int delay, input int busy);
        if (delay == 0) op_ready = 1'b0;
        wait_val();
        check("present_data", op_data, w);
        repeat (delay - 1) begin
            @(negedge clk);
            check("hold_val", op_val, 1'b1);
            check("hold_data", op_data, w);
        end
        op_ready = 1'b0;
        @(negedge clk);
        check("val_drop", op_val, 1'b0);
        repeat (busy - 1) @(negedge clk);
        op_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{word: 32'h01010101, delay: 1, busy: 5};
        tbl[1] = '{word: 32'h02020202, delay: 2, busy: 5};
        tbl[2] = '{word: 32'h03030303, delay: 0, busy: 5};
        tbl[3] = '{word: 32'h04040404, delay: 3, busy: 5};
        tbl[4] = '{word: 32'h80FF7F00, delay: 1, busy: 2};

        rstn = 1'b0; sw_rst = 1'b0; wr_en = 1'b0; wr_data = 32'd0; op_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_op_val", op_val, 1'b0);
        check("rst_op_data", op_data, 32'd0);
        check("rst_full", full, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_ovf", ovf, 1'b0);
        check("rst_tx", tx_count, 16'd0);
        #2 rstn = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("idle_op_val", op_val, 1'b0);
            check("idle_empty", empty, 1'b1);
            check("idle_tx", tx_count, 16'd0);
        end

        // Single word: present two edges after the write, accepted after three cycles.
        write_word(32'h02030402);
        check("single_empty_after_n", empty, 1'b0);
        check("single_val_after_n", op_val, 1'b0);
        @(negedge clk);
        check("single_val_after_n1", op_val, 1'b1);
        check("single_data", op_data, 32'h02030402);
        repeat (2) @(negedge clk);
        op_ready = 1'b0;
        @(negedge clk);
        check("single_val_fall", op_val, 1'b0);
        check("single_tx", tx_count, 16'd1);
        op_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("single_gap", op_val, 1'b0);
        pulse_sw_rst();

        // Burst: back-to-back writes, then drained in order.
        for (int i = 0; i < 4; i++) write_word(tbl[i].word);
        check("burst_full", full, 1'b1);
        for (int i = 0; i < 4; i++) serve(tbl[i].word, tbl[i].delay, tbl[i].busy);
        check("burst_tx", tx_count, 16'd4);
        check("burst_ovf", ovf, 1'b0);
        check("burst_empty", empty, 1'b1);
        pulse_sw_rst();

        // Overflow with the multiplier stalled.
        for (int i = 0; i < 5; i++) write_word(32'h10000000 + 32'(i));
        check("ovf_set", ovf, 1'b1);
        check("ovf_full", full, 1'b1);
        for (int i = 0; i < 4; i++) serve(32'h10000000 + 32'(i), 1, 2);
        repeat (10) begin
            @(negedge clk);
            check("ovf_no_extra", op_val, 1'b0);
        end
        check("ovf_tx", tx_count, 16'd4);
        pulse_sw_rst();

        // Write while full in the same cycle as a pop: word dropped, occupancy falls.
        for (int i = 0; i < 4; i++) write_word(32'h20000000 + 32'(i));
        wait_val();
        op_ready = 1'b0;
        wr_en    = 1'b1;
        wr_data  = 32'hDEADBEEF;
        @(negedge clk);
        wr_en    = 1'b0;
        check("wrpop_ovf", ovf, 1'b1);
        check("wrpop_full", full, 1'b0);
        check("wrpop_tx", tx_count, 16'd1);
        op_ready = 1'b1;
        @(negedge clk);
        for (int i = 1; i < 4; i++) serve(32'h20000000 + 32'(i), 2, 1);
        check("wrpop_empty", empty, 1'b1);
        pulse_sw_rst();

        // Corner values held through PRESENT.
        write_word(32'hFFFFFFFF);
        serve(32'hFFFFFFFF, 4, 2);
        write_word(tbl[4].word);
        serve(tbl[4].word, tbl[4].delay, tbl[4].busy);
        check("corner_tx", tx_count, 16'd2);
        pulse_sw_rst();

        // Soft reset while presenting with two words queued.
        for (int i = 0; i < 4; i++) write_word(32'h30000000 + 32'(i));
        serve(32'h30000000, 1, 1);
        wait_val();
        check("swr_pre_tx", tx_count, 16'd1);
        pulse_sw_rst();
        check("swr_val", op_val, 1'b0);
        check("swr_empty", empty, 1'b1);
        check("swr_tx", tx_count, 16'd0);
        check("swr_ovf", ovf, 1'b0);
        check("swr_data", op_data, 32'd0);
        repeat (10) begin
            @(negedge clk);
            check("swr_quiet", op_val, 1'b0);
        end
        write_word(32'h0A0B0C0D);
        serve(32'h0A0B0C0D, 1, 1);
        check("swr_after_tx", tx_count, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/complex_nr_op_feeder.md
# complex_nr_op_feeder

Operand feeder placed directly upstream of the complex number multiplier. It buffers packed operand words {op_1_re, op_1_im, op_2_re, op_2_im} from a host-side write port in a small FIFO. It presents them one at a time to the multiplier over the op_val/op_ready handshake and counts completed handoffs. It drives exactly the multiplier inputs sw_rst-qualified op_val and op_data.

## Interface
- DATA_WIDTH, 8, width of each real/imaginary operand field
- DEPTH, 4, FIFO depth in operand words; power of two, ≥2
- CNT_WIDTH, 16, width of the handoff counter
- clk  input  1  single clock; all logic on posedge
- rstn  input  1  reset, asynchronous, active-low
- sw_rst  input  1  software reset, synchronous, active-high
- wr_en  input  1  host write strobe, one word per cycle
- wr_data  input  4*DATA_WIDTH  packed word, [4*DW-1 -: DW]=op_1_re, then op_1_im, op_2_re, [DW-1:0]=op_2_im
- full  output  1  FIFO holds DEPTH words
- empty  output  1  FIFO holds zero words
- ovf  output  1  sticky: write attempted while full
- op_ready  input  1  multiplier idle and able to take operands
- op_val  output  1  operands valid to multiplier
- op_data  output  4*DATA_WIDTH  operands to multiplier, same packing as wr_data
- tx_count  output  CNT_WIDTH  number of completed handoffs, wraps at 2^CNT_WIDTH

## Operation
- FIFO: read/write pointers with one extra wrap bit.
  - full = pointers equal except MSB.
  - empty = pointers fully equal.
- Write when wr_en && !full stores wr_data.
- wr_en && full drops the word and sets ovf. This holds even if a pop occurs in the same cycle.
- FSM states:
  - IDLE (op_val=0): if !empty, load op_data from FIFO head and go to PRESENT.
  - PRESENT (op_val=1, op_data held stable): when op_ready is sampled 0, the handoff is accepted. Pop the FIFO, increment tx_count, and go to WAIT_RDY.
  - WAIT_RDY (op_val=0): when op_ready is sampled 1, go to IDLE.
- Acceptance is defined by op_ready falling while op_val=1.
- If op_ready is already 0 on entry to PRESENT, acceptance happens on the first PRESENT cycle. The multiplier never drops op_ready unless it is busy.
- op_data is not modified while op_val=1. It keeps its last value in IDLE/WAIT_RDY.
- sw_rst has the same effect as rstn, applied synchronously, and has priority over every other input that cycle:
  - empties the FIFO
  - sets FSM to IDLE
  - sets op_val=0 and op_data=0
  - clears ovf and tx_count
  - a word in PRESENT is discarded and not counted.

## Timing
- Reset values (rstn=0 or sw_rst=1): op_val=0, op_data=0, full=0, empty=1, ovf=0, tx_count=0, FSM=IDLE.
- Latency from write to present: wr_en sampled at edge N into an empty FIFO gives empty=0 after N. op_val=1 with the word on op_data after edge N+1.
- Handoff: op_ready sampled 0 at edge M in PRESENT gives op_val=0 and tx_count+1 after M.
- Next presentation: op_ready sampled 1 at edge K in WAIT_RDY, FIFO non-empty. The FSM is in IDLE after K, and op_val=1 after K+1. Minimum gap is 2 cycles of op_val low.
- A write and a pop in the same cycle on a non-full FIFO leave the occupancy unchanged.
- Pointer wrap at DEPTH is transparent. Order is strictly FIFO.
- full, empty and ovf are registered and update on the edge of the causing event.

## Structure
- Shared package complex_nr_mult_pkg holds:
  - FSM state encoding localparams IDLE, PRESENT, WAIT_RDY
  - field-slice helper constants for the 4-field packing, shared with the multiplier and its bench.
- Sub-module complex_nr_op_fifo (parameters DATA_WIDTH*4, DEPTH) contains the storage, pointers, full, empty and ovf.
- The feeder top holds the FSM, op_data register and tx_count.

## Test plan
- Reset/idle: rstn low then high, no writes. op_val=0, empty=1, tx_count=0 for 20 cycles.
- Single word (DATA_WIDTH=8): write (2,3,4,2).
  - op_val rises 2 cycles later with op_data=0x02030402.
  - Multiplier model drops op_ready 3 cycles later; op_val falls next edge and tx_count=1.
- Burst/order: write 0x01010101..0x04040404 back-to-back with the model busy 5 cycles per op.
  - Words appear on op_data in write order.
  - full=1 after the 4th write; tx_count=4 at the end; ovf=0.
- Overflow: with op_ready held 1 and no acceptance (model stalled), write 5 words.
  - 5th is dropped and ovf=1.
  - Only 4 handoffs ever occur.
- Corner values: write 0xFFFFFFFF. op_data=0xFFFFFFFF stable through the entire PRESENT interval.
- sw_rst mid-PRESENT: pulse sw_rst for one cycle while op_val=1 with 2 words queued.
  - Next edge gives op_val=0, empty=1, tx_count=0, ovf=0.
  - No further op_val until a new write.
